// File: rtl/serial_adder_nbit.sv
// Multi-cycle adder: WIDTH-bit operands summed DIGIT bits per clock with a registered inter-digit carry.
// Optional macro SERIAL_ADDER_SUBTRACT_EN adds the Sub input and the Overflow output.
module serial_adder_nbit #(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
`ifdef SERIAL_ADDER_SUBTRACT_EN
   input  logic             Sub,
   output logic             Overflow,
`endif
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry
);

   localparam int NDIG = WIDTH / DIGIT;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   generate
      if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
         $error("serial_adder_nbit: DIGIT must be in 1..WIDTH and divide WIDTH");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, psum, psum_nxt;
   logic             carry_r;
   logic [CW-1:0]    cnt;
   logic [DIGIT-1:0] dsum;
   logic             dcarry;
   logic             last;

   assign last = (cnt == CW'(NDIG - 1));
   assign Busy = (state != IDLE);
   assign Done = (state == DONE);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Start) state_nxt = RUN;
         RUN:     if (last)  state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // One digit slice; the result lands in the partial sum at the current digit slot.
   always_comb begin
      {dcarry, dsum} = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]}
                       + (DIGIT+1)'(carry_r);
      psum_nxt = psum;
      psum_nxt[cnt*DIGIT +: DIGIT] = dsum;
   end

`ifdef SERIAL_ADDER_SUBTRACT_EN
   logic a_msb, b_msb;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         a_sh    <= '0;
         b_sh    <= '0;
         psum    <= '0;
         carry_r <= 1'b0;
         cnt     <= '0;
         Sum     <= '0;
         Carry   <= 1'b0;
`ifdef SERIAL_ADDER_SUBTRACT_EN
         a_msb    <= 1'b0;
         b_msb    <= 1'b0;
         Overflow <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (Start) begin
               a_sh <= A;
               cnt  <= '0;
               psum <= '0;
`ifdef SERIAL_ADDER_SUBTRACT_EN
               // Subtract as A + ~B + 1; Cin is irrelevant in that mode.
               b_sh    <= Sub ? ~B : B;
               carry_r <= Sub ? 1'b1 : Cin;
               a_msb   <= A[WIDTH-1];
               b_msb   <= Sub ? ~B[WIDTH-1] : B[WIDTH-1];
`else
               b_sh    <= B;
               carry_r <= Cin;
`endif
            end
            RUN: begin
               a_sh    <= a_sh >> DIGIT;
               b_sh    <= b_sh >> DIGIT;
               carry_r <= dcarry;
               cnt     <= cnt + CW'(1);
               psum    <= psum_nxt;
               if (last) begin
                  Sum   <= psum_nxt;
                  Carry <= dcarry;
`ifdef SERIAL_ADDER_SUBTRACT_EN
                  Overflow <= (a_msb == b_msb) && (psum_nxt[WIDTH-1] != a_msb);
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Directed bench for serial_adder_nbit: main DIGIT=4 instance plus DIGIT=1 and DIGIT=16 instances.
module tb_serial_adder_nbit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [15:0] a = '0, b = '0;
   logic        cin = 1'b0;
   logic        sub = 1'b0;
   logic [2:0]  busy, done, carry;
   logic [15:0] sum4, sum1, sum16;
   logic [2:0]  ovf;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   serial_adder_nbit #(.WIDTH(16), .DIGIT(4)) dut (
      .clk(clk), .reset(reset), .Start(start), .A(a), .B(b), .Cin(cin),
`ifdef SERIAL_ADDER_SUBTRACT_EN
      .Sub(sub), .Overflow(ovf[0]),
`endif
      .Busy(busy[0]), .Done(done[0]), .Sum(sum4), .Carry(carry[0]));

   serial_adder_nbit #(.WIDTH(16), .DIGIT(1)) dut_d1 (
      .clk(clk), .reset(reset), .Start(start), .A(a), .B(b), .Cin(cin),
`ifdef SERIAL_ADDER_SUBTRACT_EN
      .Sub(sub), .Overflow(ovf[1]),
`endif
      .Busy(busy[1]), .Done(done[1]), .Sum(sum1), .Carry(carry[1]));

   serial_adder_nbit #(.WIDTH(16), .DIGIT(16)) dut_d16 (
      .clk(clk), .reset(reset), .Start(start), .A(a), .B(b), .Cin(cin),
`ifdef SERIAL_ADDER_SUBTRACT_EN
      .Sub(sub), .Overflow(ovf[2]),
`endif
      .Busy(busy[2]), .Done(done[2]), .Sum(sum16), .Carry(carry[2]));

`ifndef SERIAL_ADDER_SUBTRACT_EN
   assign ovf = '0;
`endif

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; start = 1'b0; sub = 1'b0;
      step(); step();
      reset = 1'b0;
   endtask

   // Present operands with Start for one accept edge, then drop Start.
   task automatic launch(input logic [15:0] av, input logic [15:0] bv, input logic cv);
      a = av; b = bv; cin = cv; start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (busy !== 3'b000 || done !== 3'b000 || sum4 !== 16'h0 || carry !== 3'b000) begin
         errors++;
         $display("FAIL reset_state busy=%b done=%b sum=%h carry=%b expected 000 000 0000 000",
                  busy, done, sum4, carry);
      end
   endtask

   task automatic test_basic();
      int lat = -1;
      do_reset();
      launch(16'h1234, 16'h4321, 1'b0);
      a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
      checks++;
      if (busy[0] !== 1'b1 || done[0] !== 1'b0) begin
         errors++;
         $display("FAIL accept_busy busy=%b done=%b expected 1 0", busy[0], done[0]);
      end
      for (int n = 1; n <= 40; n++) begin
         step();
         if (done[0] === 1'b1) begin lat = n; break; end
      end
      checks++;
      if (lat != 4) begin
         errors++;
         $display("FAIL basic_latency got %0d expected 4", lat);
      end
      checks++;
      if (sum4 !== 16'h5555 || carry[0] !== 1'b0 || busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL basic_sum sum=%h carry=%b busy=%b expected 5555 0 1", sum4, carry[0], busy[0]);
      end
      step();
      checks++;
      if (done[0] !== 1'b0 || busy[0] !== 1'b0 || sum4 !== 16'h5555) begin
         errors++;
         $display("FAIL after_done done=%b busy=%b sum=%h expected 0 0 5555", done[0], busy[0], sum4);
      end
   endtask

   task automatic test_carry_ripple();
      logic [15:0] av [3] = '{16'hFFFF, 16'hFFFF, 16'h8000};
      logic [15:0] bv [3] = '{16'h0001, 16'h0000, 16'h8000};
      logic        cv [3] = '{1'b0, 1'b1, 1'b1};
      logic [15:0] es [3] = '{16'h0000, 16'h0000, 16'h0001};
      for (int i = 0; i < 3; i++) begin
         bit seen = 0;
         do_reset();
         launch(av[i], bv[i], cv[i]);
         for (int n = 1; n <= 40; n++) begin
            step();
            if (done[0] === 1'b1) begin seen = 1; break; end
         end
         checks++;
         if (!seen || sum4 !== es[i] || carry[0] !== 1'b1) begin
            errors++;
            $display("FAIL ripple_%0d seen=%0d sum=%h carry=%b expected 1 %h 1",
                     i, seen, sum4, carry[0], es[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int          pulses = 0;
      logic [15:0] exp_sum [3] = '{16'h3333, 16'h1606, 16'h1C0C};
      do_reset();
      a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
      step();  // accept edge 0
      for (int k = 1; k <= 17; k++) begin
         a = 16'h1000 + 16'(k);
         b = 16'(k * 256);
         step();
         if (done[0] === 1'b1) begin
            checks++;
            if (k != 4 + 6 * pulses || pulses > 2 || sum4 !== exp_sum[pulses]) begin
               errors++;
               $display("FAIL b2b_done edge=%0d sum=%h expected edge %0d sum %h",
                        k, sum4, 4 + 6 * pulses, exp_sum[pulses % 3]);
            end
            pulses++;
         end
         if ((k % 6) == 5) begin
            checks++;
            if (busy[0] !== 1'b0) begin
               errors++;
               $display("FAIL b2b_idle edge=%0d busy=%b expected 0", k, busy[0]);
            end
         end
      end
      start = 1'b0;
      checks++;
      if (pulses != 3) begin
         errors++;
         $display("FAIL b2b_pulses got %0d expected 3", pulses);
      end
   endtask

   task automatic test_reset_abort();
      int pulses = 0;
      launch(16'h0F0F, 16'h0101, 1'b0);  // DUT still holds 1C0C from previous test
      step();                             // now in second RUN cycle
      reset = 1'b1;
      step();
      reset = 1'b0;
      checks++;
      if (busy[0] !== 1'b0 || done[0] !== 1'b0 || sum4 !== 16'h0 || carry[0] !== 1'b0) begin
         errors++;
         $display("FAIL abort_state busy=%b done=%b sum=%h carry=%b expected 0 0 0000 0",
                  busy[0], done[0], sum4, carry[0]);
      end
      for (int n = 0; n < 10; n++) begin
         step();
         if (done[0] === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || sum4 !== 16'h0) begin
         errors++;
         $display("FAIL abort_no_done pulses=%0d sum=%h expected 0 0000", pulses, sum4);
      end
   endtask

   task automatic test_digit_builds();
      int e1 = -1, e16 = -1;
      do_reset();
      launch(16'hA5A5, 16'h5A5B, 1'b0);
      for (int n = 1; n <= 40; n++) begin
         step();
         if (done[1] === 1'b1 && e1 < 0)  e1 = n;
         if (done[2] === 1'b1 && e16 < 0) e16 = n;
         if (e1 >= 0 && e16 >= 0) break;
      end
      checks++;
      if (e1 != 16 || sum1 !== 16'h0000 || carry[1] !== 1'b1) begin
         errors++;
         $display("FAIL digit1 latency=%0d sum=%h carry=%b expected 16 0000 1", e1, sum1, carry[1]);
      end
      checks++;
      if (e16 != 1 || sum16 !== 16'h0000 || carry[2] !== 1'b1) begin
         errors++;
         $display("FAIL digit16 latency=%0d sum=%h carry=%b expected 1 0000 1", e16, sum16, carry[2]);
      end
   endtask

`ifdef SERIAL_ADDER_SUBTRACT_EN
   task automatic test_subtract();
      logic [15:0] av [2] = '{16'h0005, 16'h8000};
      logic [15:0] bv [2] = '{16'h0007, 16'h0001};
      logic [15:0] es [2] = '{16'hFFFE, 16'h7FFF};
      logic        ec [2] = '{1'b0, 1'b1};
      logic        eo [2] = '{1'b0, 1'b1};
      for (int i = 0; i < 2; i++) begin
         bit seen = 0;
         do_reset();
         sub = 1'b1;
         launch(av[i], bv[i], 1'b1);
         sub = 1'b0;
         for (int n = 1; n <= 40; n++) begin
            step();
            if (done[0] === 1'b1) begin seen = 1; break; end
         end
         checks++;
         if (!seen || sum4 !== es[i] || carry[0] !== ec[i] || ovf[0] !== eo[i]) begin
            errors++;
            $display("FAIL sub_%0d seen=%0d sum=%h carry=%b ovf=%b expected 1 %h %b %b",
                     i, seen, sum4, carry[0], ovf[0], es[i], ec[i], eo[i]);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_carry_ripple();
      test_back_to_back();
      test_reset_abort();
      test_digit_builds();
`ifdef SERIAL_ADDER_SUBTRACT_EN
      test_subtract();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
